// File: rtl/mem_arb_pkg.sv
// Shared constants and state encoding for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-lane round-robin pick: a lone requester wins; on a tie the lane not served last wins.
// Purely combinational, no backpressure of its own.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       any,
    output logic       winner
);

    assign any    = |req;
    assign winner = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two requesters onto one memory port; grant registers the request, completes on mem_ready (>= 2 cycles).
// Requesters hold wen/ren until their req_ready pulse; the memory stalls the winner by withholding mem_ready.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
    input  logic [NUM_REQ-1:0]              req_wen,
    input  logic [NUM_REQ-1:0]              req_ren,
    output logic [DATA_WIDTH-1:0]           req_rdata,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    output logic [DATA_WIDTH/8-1:0]        mem_wstrb,
    output logic                            mem_wen,
    output logic                            mem_ren,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    input  logic                            mem_ready,
    output logic                            grant_id
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    state_t                  state, state_nxt;
    logic                    last_grant;
    logic [NUM_REQ-1:0]      req_lane;
    logic                    pick_any, pick_lane;
    logic                    done;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [STRB_WIDTH-1:0]   lat_wstrb;
    logic                    lat_wr;

    assign req_lane = req_wen | req_ren;

    rr_pick2 u_pick (
        .req        (req_lane),
        .last_grant (last_grant),
        .any        (pick_any),
        .winner     (pick_lane)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // mem_ready only counts while BUSY, so a ready left high after completion is ignored.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A lane raising both enables is treated as a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wstrb  <= '0;
            lat_wr     <= 1'b0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (state == IDLE && pick_any) begin
                lat_addr  <= pick_lane ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                       : req_addr[ADDR_WIDTH-1:0];
                lat_wdata <= pick_lane ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                       : req_wdata[DATA_WIDTH-1:0];
                lat_wstrb <= pick_lane ? req_wstrb[2*STRB_WIDTH-1:STRB_WIDTH]
                                       : req_wstrb[STRB_WIDTH-1:0];
                lat_wr    <= req_wen[pick_lane];
                grant_id  <= pick_lane;
            end
            if (done) begin
                last_grant <= grant_id;
            end
        end
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_wstrb = lat_wstrb;
    assign mem_wen   = (state == BUSY) &&  lat_wr;
    assign mem_ren   = (state == BUSY) && !lat_wr;
    assign req_ready = done ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign req_rdata = done ? mem_rdata : '0;

endmodule
